// File: rtl/alu_seq_pkg.sv
// alu_seq_pkg: shared types and constants for the ALU control sequencer.
//   state_t   : sequencer states
//   OP_*      : ALU opcodes carried in the sel field
//   instr_t   : control header of an instruction word. It occupies bits
//               [DATA_W+5:DATA_W]; the B operand fills bits [DATA_W-1:0].
//   OFF_*     : field offsets above DATA_W inside the instruction word
package alu_seq_pkg;

    typedef enum logic [1:0] {IDLE, DRIVE, LOAD, CLEAR} state_t;

    localparam logic [2:0] OP_NOT = 3'b000;
    localparam logic [2:0] OP_AND = 3'b001;
    localparam logic [2:0] OP_OR  = 3'b010;
    localparam logic [2:0] OP_XOR = 3'b011;
    localparam logic [2:0] OP_INC = 3'b100;
    localparam logic [2:0] OP_DEC = 3'b101;
    localparam logic [2:0] OP_ADD = 3'b110;
    localparam logic [2:0] OP_SUB = 3'b111;

    localparam int INSTR_HDR_W = 6;
    localparam int OFF_DST = 0;
    localparam int OFF_SRC = 1;
    localparam int OFF_SEL = 2;
    localparam int OFF_CLR = 5;

    typedef struct packed {
        logic       clr;
        logic [2:0] sel;
        logic       src;
        logic       dst;
    } instr_t;

endpackage

// File: rtl/alu_sequencer_if.sv
// alu_sequencer_if: instruction push channel (valid/ready).
//   in_valid : instruction word valid (master -> slave)
//   in_instr : {clr, sel[2:0], src, dst, b[DATA_W-1:0]} (master -> slave)
//   in_ready : queue can accept a word (slave -> master)
interface alu_sequencer_if #(parameter int DATA_W = 4);
    logic              in_valid;
    logic [DATA_W+5:0] in_instr;
    logic              in_ready;

    modport master (output in_valid, output in_instr, input in_ready);
    modport slave  (input in_valid, input in_instr, output in_ready);
endinterface

// File: rtl/alu_seq_fifo.sv
// alu_seq_fifo: DEPTH x W synchronous FIFO, show-ahead read port.
//   clk, rst_n : clock, asynchronous active-low reset (flushes the queue)
//   push/wdata : write request; ignored while full
//   pop/rdata  : rdata is the head entry; pop ignored while empty
//   full/empty : occupancy flags
module alu_seq_fifo #(
    parameter int DEPTH = 4,
    parameter int W     = 10
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         push,
    input  logic [W-1:0] wdata,
    input  logic         pop,
    output logic [W-1:0] rdata,
    output logic         full,
    output logic         empty
);
    localparam int AW = $clog2(DEPTH);

    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic [AW:0]   count;   // one extra bit separates full from empty
    logic          push_ok, pop_ok;

    assign full    = (count == (AW+1)'(DEPTH));
    assign empty   = (count == '0);
    assign push_ok = push && !full;
    assign pop_ok  = pop && !empty;
    assign rdata   = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (push_ok) mem[wr_ptr] <= wdata;
    end

    // DEPTH is a power of two, so the pointers wrap naturally.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push_ok) wr_ptr <= wr_ptr + 1'b1;
            if (pop_ok)  rd_ptr <= rd_ptr + 1'b1;
            case ({push_ok, pop_ok})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end
endmodule

// File: rtl/alu_sequencer.sv
// alu_sequencer: expands queued micro-instructions into register/ALU control
// strobes for the two-register sequential ALU datapath.
//   clk         : system clock
//   MRbar       : asynchronous active-low reset (aborts sequence, flushes queue)
//   up          : instruction push channel (slave side)
//   carry_in    : ALU carry-out, captured at the end of LOAD
//   EObar1/2    : active-low, reg1/reg2 drives the ALU A bus
//   EIbar1/2    : active-low, reg1/reg2 loads Y
//   sel, b_out  : ALU opcode and B operand
//   MR          : active-high master reset to both registers
//   reg_clk     : register load clock (high during LOAD)
//   carry_q     : carry captured at the last LOAD, cleared by CLEAR
//   busy        : sequencer active or queue non-empty
//   retired     : (RETIRE_COUNT_EN only) count of completed LOAD/CLEAR, wraps
// Optional feature macro: RETIRE_COUNT_EN
module alu_sequencer
    import alu_seq_pkg::*;
#(
    parameter int DEPTH      = 4,
    parameter int DATA_W     = 4,
    parameter int SETTLE_CYC = 1
) (
    input  logic              clk,
    input  logic              MRbar,
    alu_sequencer_if.slave    up,
    input  logic              carry_in,
    output logic              EObar1,
    output logic              EObar2,
    output logic              EIbar1,
    output logic              EIbar2,
    output logic [2:0]        sel,
    output logic [DATA_W-1:0] b_out,
    output logic              MR,
    output logic              reg_clk,
    output logic              carry_q,
    output logic              busy
`ifdef RETIRE_COUNT_EN
    ,
    output logic [7:0]        retired
`endif
);
    localparam int CW = (SETTLE_CYC > 1) ? $clog2(SETTLE_CYC) : 1;

    state_t            state, state_nxt;
    logic [CW-1:0]     cnt;
    instr_t            cur_hdr, cur_hdr_nxt, fifo_hdr;
    logic [DATA_W-1:0] cur_b, cur_b_nxt, fifo_b;
    logic [DATA_W+5:0] fifo_word;
    logic              full, empty, pop;
    logic              drv, ld;

    alu_seq_fifo #(.DEPTH(DEPTH), .W(DATA_W + INSTR_HDR_W)) u_fifo (
        .clk   (clk),
        .rst_n (MRbar),
        .push  (up.in_valid),
        .wdata (up.in_instr),
        .pop   (pop),
        .rdata (fifo_word),
        .full  (full),
        .empty (empty)
    );

    assign up.in_ready = !full;
    assign fifo_hdr    = instr_t'(fifo_word[DATA_W+5:DATA_W]);
    assign fifo_b      = fifo_word[DATA_W-1:0];
    assign busy        = (state != IDLE) || !empty;

    always_ff @(posedge clk or negedge MRbar) begin
        if (!MRbar) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt   = state;
        pop         = 1'b0;
        cur_hdr_nxt = cur_hdr;
        cur_b_nxt   = cur_b;
        case (state)
            IDLE: if (!empty) begin
                pop         = 1'b1;
                cur_hdr_nxt = fifo_hdr;
                cur_b_nxt   = fifo_b;
                state_nxt   = fifo_hdr.clr ? CLEAR : DRIVE;
            end
            DRIVE:   if (cnt == CW'(SETTLE_CYC - 1)) state_nxt = LOAD;
            LOAD:    state_nxt = IDLE;
            CLEAR:   state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
        // Outputs are registered from the next state so they line up with it.
        drv = (state_nxt == DRIVE) || (state_nxt == LOAD);
        ld  = (state_nxt == LOAD);
    end

    always_ff @(posedge clk or negedge MRbar) begin
        if (!MRbar) begin
            cur_hdr <= '0;
            cur_b   <= '0;
            cnt     <= '0;
            EObar1  <= 1'b1;
            EObar2  <= 1'b1;
            EIbar1  <= 1'b1;
            EIbar2  <= 1'b1;
            sel     <= '0;
            b_out   <= '0;
            MR      <= 1'b0;
            reg_clk <= 1'b0;
            carry_q <= 1'b0;
        end else begin
            cur_hdr <= cur_hdr_nxt;
            cur_b   <= cur_b_nxt;
            cnt     <= (state == DRIVE && state_nxt == DRIVE) ? cnt + 1'b1 : '0;
            EObar1  <= !(drv && !cur_hdr_nxt.src);
            EObar2  <= !(drv &&  cur_hdr_nxt.src);
            EIbar1  <= !(ld && !cur_hdr_nxt.dst);
            EIbar2  <= !(ld &&  cur_hdr_nxt.dst);
            sel     <= drv ? cur_hdr_nxt.sel : 3'b000;
            b_out   <= drv ? cur_b_nxt : '0;
            MR      <= (state_nxt == CLEAR);
            reg_clk <= ld;
            // Carry is taken on the edge that leaves LOAD, i.e. as reg_clk falls.
            if (state == LOAD)       carry_q <= carry_in;
            else if (state == CLEAR) carry_q <= 1'b0;
        end
    end

`ifdef RETIRE_COUNT_EN
    always_ff @(posedge clk or negedge MRbar) begin
        if (!MRbar)                             retired <= '0;
        else if (state == LOAD || state == CLEAR) retired <= retired + 8'd1;
    end
`endif

endmodule

// File: tb/tb_alu_sequencer.sv
// tb_alu_sequencer: self-checking bench for alu_sequencer. A timeline model
// (queue of words plus a schedule of expected per-cycle output records) is
// compared against the DUT every cycle; directed scenarios add literal checks.
module tb_alu_sequencer;
    localparam int DEPTH  = 4;
    localparam int DATA_W = 4;
    localparam int S      = 1;
    localparam int IW     = DATA_W + 6;
    localparam logic [12:0] REC_IDLE = 13'b1111_000_0000_00;

    logic clk = 1'b0;
    logic MRbar = 1'b0;
    logic carry_in = 1'b0;
    logic EObar1, EObar2, EIbar1, EIbar2, MR, reg_clk, carry_q, busy;
    logic [2:0] sel;
    logic [DATA_W-1:0] b_out;
`ifdef RETIRE_COUNT_EN
    logic [7:0] retired;
`endif

    alu_sequencer_if #(.DATA_W(DATA_W)) up ();

    alu_sequencer #(.DEPTH(DEPTH), .DATA_W(DATA_W), .SETTLE_CYC(S)) dut (
        .clk(clk), .MRbar(MRbar), .up(up), .carry_in(carry_in),
        .EObar1(EObar1), .EObar2(EObar2), .EIbar1(EIbar1), .EIbar2(EIbar2),
        .sel(sel), .b_out(b_out), .MR(MR), .reg_clk(reg_clk),
        .carry_q(carry_q), .busy(busy)
`ifdef RETIRE_COUNT_EN
        , .retired(retired)
`endif
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;
    int rclk_pulses = 0;
    int mr_cycles = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h t=%0t", nm, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    // Record layout: {EObar1,EObar2,EIbar1,EIbar2,sel,b,MR,reg_clk}
    logic [IW-1:0] mq[$];
    logic [12:0]   sched[$];
    logic [12:0]   disp = REC_IDLE;
    logic          carry_m = 1'b0;
    logic [7:0]    ret_m = 8'd0;

    function automatic logic [12:0] rec(input int kind, input logic [IW-1:0] w);
        logic src, dst;
        logic [2:0] op;
        logic [DATA_W-1:0] b;
        src = w[DATA_W+1];
        dst = w[DATA_W];
        op  = w[DATA_W+4:DATA_W+2];
        b   = w[DATA_W-1:0];
        if (kind == 0)      return {src, ~src, 2'b11, op, b, 2'b00};
        else if (kind == 1) return {src, ~src, dst, ~dst, op, b, 2'b01};
        else                return {4'b1111, 3'b000, 4'b0000, 2'b10};
    endfunction

    always @(posedge clk or negedge MRbar) begin
        if (!MRbar) begin
            mq.delete();
            sched.delete();
            disp = REC_IDLE;
            carry_m = 1'b0;
            ret_m = 8'd0;
        end else begin
            logic do_push;
            logic [IW-1:0] w;
            do_push = up.in_valid && (mq.size() < DEPTH);
            if (disp[0]) begin carry_m = carry_in; ret_m = ret_m + 8'd1; end
            if (disp[1]) begin carry_m = 1'b0;     ret_m = ret_m + 8'd1; end
            if (disp == REC_IDLE && mq.size() > 0) begin
                w = mq.pop_front();
                if (w[IW-1]) sched.push_back(rec(2, w));
                else begin
                    repeat (S) sched.push_back(rec(0, w));
                    sched.push_back(rec(1, w));
                end
            end
            if (do_push) mq.push_back(up.in_instr);
            disp = (sched.size() > 0) ? sched.pop_front() : REC_IDLE;
        end
    end

    // ---------------- per-cycle compare ----------------
    always @(negedge clk) begin
        if (MRbar) begin
            chk("outputs", {19'd0, EObar1, EObar2, EIbar1, EIbar2, sel, b_out, MR, reg_clk},
                {19'd0, disp});
            chk("carry_q", {31'd0, carry_q}, {31'd0, carry_m});
            chk("in_ready", {31'd0, up.in_ready}, {31'd0, mq.size() < DEPTH});
            chk("busy", {31'd0, busy}, {31'd0, (disp != REC_IDLE) || (mq.size() > 0)});
            chk("inv_eobar", {31'd0, EObar1 | EObar2}, 32'd1);
            chk("inv_eibar_load", {31'd0, (EIbar1 & EIbar2) | reg_clk}, 32'd1);
            chk("inv_mr_rclk", {31'd0, MR & reg_clk}, 32'd0);
`ifdef RETIRE_COUNT_EN
            chk("retired", {24'd0, retired}, {24'd0, ret_m});
`endif
            if (reg_clk) rclk_pulses++;
            if (MR) mr_cycles++;
        end
    end

    // ---------------- stimulus ----------------
    task automatic push_word(input logic [IW-1:0] w);
        @(negedge clk);
        up.in_valid = 1'b1;
        up.in_instr = w;
        @(negedge clk);
        up.in_valid = 1'b0;
    endtask

    task automatic wait_idle();
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (!busy) return;
        end
        checks++;
        failures++;
        $display("FAIL wait_idle timeout busy=%0b expected=0", busy);
    endtask

    task automatic do_reset();
        @(negedge clk);
        MRbar = 1'b0;
        up.in_valid = 1'b0;
        @(negedge clk);
        MRbar = 1'b1;
    endtask

    initial begin
        int p0, m0;
        up.in_valid = 1'b0;
        up.in_instr = '0;
        repeat (2) @(negedge clk);

        // reset values
        chk("rst_outputs", {19'd0, EObar1, EObar2, EIbar1, EIbar2, sel, b_out, MR, reg_clk},
            {19'd0, 13'b1111_000_0000_00});
        chk("rst_carry", {31'd0, carry_q}, 32'd0);
        chk("rst_ready", {31'd0, up.in_ready}, 32'd1);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        MRbar = 1'b1;

        // 1: ADD, src=reg1, dst=reg2, b=0011
        @(negedge clk);
        up.in_valid = 1'b1;
        up.in_instr = {1'b0, 3'b110, 1'b0, 1'b1, 4'b0011};
        @(negedge clk);
        up.in_valid = 1'b0;
        @(negedge clk);
        chk("t1_drive", {24'd0, EObar1, EObar2, sel, b_out}, {24'd0, 9'b0_1_110_0011});
        @(negedge clk);
        chk("t1_load", {29'd0, EIbar1, EIbar2, reg_clk}, {29'd0, 3'b101});
        @(negedge clk);
        chk("t1_idle", {30'd0, busy, EObar1}, {30'd0, 2'b01});

        // 4: carry capture
        carry_in = 1'b1;
        push_word({1'b0, 3'b111, 1'b1, 1'b0, 4'b0101});
        wait_idle();
        chk("t4_carry_sub", {31'd0, carry_q}, 32'd1);
        carry_in = 1'b0;
        push_word({1'b0, 3'b000, 1'b0, 1'b0, 4'b0000});
        wait_idle();
        chk("t4_carry_not", {31'd0, carry_q}, 32'd0);

        // 3: CLEAR after carry set
        carry_in = 1'b1;
        push_word({1'b0, 3'b111, 1'b0, 1'b1, 4'b1111});
        wait_idle();
        p0 = rclk_pulses;
        m0 = mr_cycles;
        push_word({1'b1, 3'b000, 1'b0, 1'b0, 4'b0000});
        wait_idle();
        chk("t3_mr_cycles", mr_cycles - m0, 32'd1);
        chk("t3_no_rclk", rclk_pulses - p0, 32'd0);
        chk("t3_carry", {31'd0, carry_q}, 32'd0);
        carry_in = 1'b0;

        // 2: back-to-back pushes fill the queue; the 7th is dropped
        p0 = rclk_pulses;
        for (int i = 0; i < 7; i++) begin
            @(negedge clk);
            if (i == 6) chk("t2_full_ready", {31'd0, up.in_ready}, 32'd0);
            up.in_valid = 1'b1;
            up.in_instr = {1'b0, 3'(i), 1'(i), ~1'(i), 4'(i)};
        end
        @(negedge clk);
        up.in_valid = 1'b0;
        wait_idle();
        chk("t2_loads", rclk_pulses - p0, 32'd6);

        // 5: reset during DRIVE
        @(negedge clk);
        up.in_valid = 1'b1;
        up.in_instr = {1'b0, 3'b001, 1'b0, 1'b0, 4'b1010};
        @(negedge clk);
        up.in_instr = {1'b0, 3'b010, 1'b1, 1'b1, 4'b0110};
        @(negedge clk);
        up.in_valid = 1'b0;
        chk("t5_in_drive", {31'd0, EObar1}, 32'd0);
        p0 = rclk_pulses;
        #2 MRbar = 1'b0;
        #1;
        chk("t5_idle_outputs", {19'd0, EObar1, EObar2, EIbar1, EIbar2, sel, b_out, MR, reg_clk},
            {19'd0, 13'b1111_000_0000_00});
        chk("t5_flushed", {30'd0, busy, up.in_ready}, {30'd0, 2'b01});
        @(negedge clk);
        MRbar = 1'b1;
        repeat (6) @(negedge clk);
        chk("t5_no_rclk", rclk_pulses - p0, 32'd0);
        chk("t5_busy", {31'd0, busy}, 32'd0);

        // random traffic against the model
        for (int i = 0; i < 400; i++) begin
            @(negedge clk);
            up.in_valid = 1'($urandom_range(0, 1));
            up.in_instr = IW'($urandom);
            up.in_instr[IW-1] = ($urandom_range(0, 7) == 0);
            carry_in = 1'($urandom_range(0, 1));
        end
        @(negedge clk);
        up.in_valid = 1'b0;
        wait_idle();

`ifdef RETIRE_COUNT_EN
        begin
            int accepted;
            accepted = 0;
            do_reset();
            for (int i = 0; i < 5000 && accepted < 257; i++) begin
                @(negedge clk);
                up.in_valid = 1'b1;
                up.in_instr = IW'($urandom);
                up.in_instr[IW-1] = ($urandom_range(0, 3) == 0);
                carry_in = 1'($urandom_range(0, 1));
                if (up.in_ready) accepted++;
            end
            @(negedge clk);
            up.in_valid = 1'b0;
            wait_idle();
            chk("t6_retired", {24'd0, retired}, 32'd1);
        end
`endif

        do_reset();
        repeat (2) @(negedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
